// File: rtl/camera_ctrl_slave.sv
// Avalon-MM register block for the camera pipeline: control, W1C status with
// overrun, interrupt, frame counter, shadowed config and per-buffer base addresses.
module camera_ctrl_slave #(
  parameter int          NUM_BUFF      = 2,
  parameter logic [15:0] DEF_WIDTH     = 16'd320,
  parameter logic [15:0] DEF_HEIGHT    = 16'd240,
  parameter logic [15:0] DEF_START_ROW = 16'h0036,
  parameter logic [15:0] DEF_START_COL = 16'h0010,
  parameter logic [15:0] DEF_ROW_SIZE  = 16'h059f,
  parameter logic [15:0] DEF_COL_SIZE  = 16'h077f,
  parameter logic [15:0] DEF_ROW_MODE  = 16'h0002,
  parameter logic [15:0] DEF_COL_MODE  = 16'h0002,
  parameter logic [15:0] DEF_EXPOSURE  = 16'h07c0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [4:0]               avs_address,
  input  logic                     avs_read,
  output logic [31:0]              avs_readdata,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  input  logic [NUM_BUFF-1:0]      buff_done_tgl,
  input  logic                     frame_start_tgl,
  output logic                     start_capture,
  output logic                     cam_soft_reset_n,
  output logic [32*NUM_BUFF-1:0]   buff_addr,
  output logic [15:0]              cfg_start_row,
  output logic [15:0]              cfg_start_col,
  output logic [15:0]              cfg_row_size,
  output logic [15:0]              cfg_col_size,
  output logic [15:0]              cfg_row_mode,
  output logic [15:0]              cfg_col_mode,
  output logic [15:0]              cfg_exposure,
  output logic [15:0]              cfg_width,
  output logic [15:0]              cfg_height,
  output logic                     irq
);

  localparam int NT    = NUM_BUFF + 1;
  localparam int NCFG  = 9;
  localparam logic [15:0] CFG_DEF [NCFG] = '{DEF_START_ROW, DEF_START_COL,
    DEF_ROW_SIZE, DEF_COL_SIZE, DEF_ROW_MODE, DEF_COL_MODE, DEF_EXPOSURE,
    DEF_WIDTH, DEF_HEIGHT};

  logic [NT-1:0]       tgl_in, sync1, sync2, edge_q, evt;
  logic [1:0]          mask_cnt;
  logic [NUM_BUFF-1:0] buff_ev;
  logic                frame_ev;

  logic [NUM_BUFF-1:0] buff_full, overrun;
  logic [NUM_BUFF-1:0] irq_en_full, irq_en_ovr;
  logic [NUM_BUFF-1:0] clr_full, clr_ovr;
  logic [15:0]         frame_cnt;
  logic [15:0]         shadow [NCFG];
  logic [15:0]         active [NCFG];
  logic [31:0]         buff_addr_q [NUM_BUFF];
  logic [31:0]         rd_data;

  logic wr_ctrl, wr_status, wr_irq_en, wr_frame;

  assign tgl_in = {frame_start_tgl, buff_done_tgl};

  // Toggle synchronisers; the edge register keeps tracking while events are masked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      edge_q   <= '0;
      mask_cnt <= 2'd0;
    end else begin
      sync1  <= tgl_in;
      sync2  <= sync1;
      edge_q <= sync2;
      if (mask_cnt != 2'd3)
        mask_cnt <= mask_cnt + 2'd1;
    end
  end

  assign evt      = (mask_cnt == 2'd3) ? (sync2 ^ edge_q) : '0;
  assign buff_ev  = evt[NUM_BUFF-1:0];
  assign frame_ev = evt[NUM_BUFF];

  assign wr_ctrl   = avs_write && (avs_address == 5'h00);
  assign wr_status = avs_write && (avs_address == 5'h01);
  assign wr_irq_en = avs_write && (avs_address == 5'h02);
  assign wr_frame  = avs_write && (avs_address == 5'h03);

  assign clr_full = wr_status ? avs_writedata[NUM_BUFF-1:0]   : '0;
  assign clr_ovr  = wr_status ? avs_writedata[8 +: NUM_BUFF]  : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_capture    <= 1'b0;
      cam_soft_reset_n <= 1'b1;
      irq_en_full      <= '0;
      irq_en_ovr       <= '0;
    end else begin
      if (wr_ctrl) begin
        start_capture    <= avs_writedata[0];
        cam_soft_reset_n <= avs_writedata[1];
      end
      if (wr_irq_en) begin
        irq_en_full <= avs_writedata[NUM_BUFF-1:0];
        irq_en_ovr  <= avs_writedata[8 +: NUM_BUFF];
      end
    end
  end

  // A new event beats a same-cycle clear, and only counts as overrun if the bit stays full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buff_full <= '0;
      overrun   <= '0;
      irq       <= 1'b0;
    end else begin
      buff_full <= buff_ev | (buff_full & ~clr_full);
      overrun   <= (buff_ev & buff_full & ~clr_full) | (overrun & ~clr_ovr);
      irq       <= |((buff_full & irq_en_full) | (overrun & irq_en_ovr));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      frame_cnt <= 16'd0;
    else if (wr_frame)
      frame_cnt <= 16'd0;
    else if (frame_ev)
      frame_cnt <= frame_cnt + 16'd1;
  end

  // Active config follows the shadow freely while stopped, otherwise only at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCFG; i++) begin
        shadow[i] <= CFG_DEF[i];
        active[i] <= CFG_DEF[i];
      end
    end else begin
      for (int i = 0; i < NCFG; i++) begin
        if (avs_write && (avs_address == 5'(i + 4)))
          shadow[i] <= avs_writedata[15:0];
        if (!start_capture || frame_ev)
          active[i] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BUFF; i++)
        buff_addr_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_BUFF; i++)
        if (avs_write && (avs_address == 5'(i + 16)))
          buff_addr_q[i] <= avs_writedata;
    end
  end

  for (genvar g = 0; g < NUM_BUFF; g++) begin : g_addr
    assign buff_addr[32*g +: 32] = buff_addr_q[g];
  end

  assign cfg_start_row = active[0];
  assign cfg_start_col = active[1];
  assign cfg_row_size  = active[2];
  assign cfg_col_size  = active[3];
  assign cfg_row_mode  = active[4];
  assign cfg_col_mode  = active[5];
  assign cfg_exposure  = active[6];
  assign cfg_width     = active[7];
  assign cfg_height    = active[8];

  always_comb begin
    rd_data = 32'd0;
    case (avs_address)
      5'h00: rd_data[1:0] = {cam_soft_reset_n, start_capture};
      5'h01: begin
        rd_data[NUM_BUFF-1:0]  = buff_full;
        rd_data[8 +: NUM_BUFF] = overrun;
      end
      5'h02: begin
        rd_data[NUM_BUFF-1:0]  = irq_en_full;
        rd_data[8 +: NUM_BUFF] = irq_en_ovr;
      end
      5'h03: rd_data[15:0] = frame_cnt;
      default: rd_data = 32'd0;
    endcase
    for (int i = 0; i < NCFG; i++)
      if (avs_address == 5'(i + 4))
        rd_data = {16'd0, shadow[i]};
    for (int i = 0; i < NUM_BUFF; i++)
      if (avs_address == 5'(i + 16))
        rd_data = buff_addr_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      avs_readdata <= 32'd0;
    else if (avs_read)
      avs_readdata <= rd_data;
  end

endmodule

// File: tb/tb_camera_ctrl_slave.sv
// Directed bench for camera_ctrl_slave: a default (2-buffer) instance and a
// 4-buffer instance share the bus; expected values are hand-computed constants.
module tb_camera_ctrl_slave;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic        frame_start_tgl;
  logic [1:0]  buff_tgl2;
  logic [3:0]  buff_tgl4;

  logic [31:0]  readdata2, readdata4, rd2, rd4;
  logic         start2, soft2, irq2, start4, soft4, irq4;
  logic [63:0]  baddr2;
  logic [127:0] baddr4;
  logic [15:0]  c2_sr, c2_sc, c2_rs, c2_cs, c2_rm, c2_cm, c2_ex, c2_w, c2_h;
  logic [15:0]  c4_sr, c4_sc, c4_rs, c4_cs, c4_rm, c4_cm, c4_ex, c4_w, c4_h;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  camera_ctrl_slave u_dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(readdata2), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .buff_done_tgl(buff_tgl2), .frame_start_tgl(frame_start_tgl),
    .start_capture(start2), .cam_soft_reset_n(soft2), .buff_addr(baddr2),
    .cfg_start_row(c2_sr), .cfg_start_col(c2_sc), .cfg_row_size(c2_rs),
    .cfg_col_size(c2_cs), .cfg_row_mode(c2_rm), .cfg_col_mode(c2_cm),
    .cfg_exposure(c2_ex), .cfg_width(c2_w), .cfg_height(c2_h), .irq(irq2)
  );

  camera_ctrl_slave #(.NUM_BUFF(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(readdata4), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .buff_done_tgl(buff_tgl4), .frame_start_tgl(frame_start_tgl),
    .start_capture(start4), .cam_soft_reset_n(soft4), .buff_addr(baddr4),
    .cfg_start_row(c4_sr), .cfg_start_col(c4_sc), .cfg_row_size(c4_rs),
    .cfg_col_size(c4_cs), .cfg_row_mode(c4_rm), .cfg_col_mode(c4_cm),
    .cfg_exposure(c4_ex), .cfg_width(c4_w), .cfg_height(c4_h), .irq(irq4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    rd2 = readdata2;
    rd4 = readdata4;
  endtask

  task automatic applyStimulus(input int which);
    @(negedge clk);
    if (which < 0) frame_start_tgl = ~frame_start_tgl;
    else if (which < 2) buff_tgl2[which] = ~buff_tgl2[which];
    else buff_tgl4[which - 2] = ~buff_tgl4[which - 2];
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    frame_start_tgl = 0; buff_tgl2 = '0; buff_tgl4 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_start", {31'd0, start2}, 32'd0);
    checkOutput("rst_soft", {31'd0, soft2}, 32'd1);
    checkOutput("rst_irq", {31'd0, irq2}, 32'd0);
    checkOutput("rst_rdata", readdata2, 32'd0);
    checkOutput("rst_width", {16'd0, c2_w}, 32'd320);
    checkOutput("rst_baddr", baddr2[31:0] | baddr2[63:32], 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Register map after reset
    bus_read(5'h00); checkOutput("ctrl", rd2, 32'h2);
    bus_read(5'h01); checkOutput("status0", rd2, 32'h0);
    bus_read(5'h02); checkOutput("irq_en0", rd2, 32'h0);
    bus_read(5'h03); checkOutput("frame0", rd2, 32'h0);
    bus_read(5'h04); checkOutput("start_row", rd2, 32'h0036);
    bus_read(5'h0A); checkOutput("exposure", rd2, 32'h07c0);
    bus_read(5'h0B); checkOutput("width", rd2, 32'd320);
    bus_read(5'h0C); checkOutput("height", rd2, 32'd240);
    bus_read(5'h10); checkOutput("baddr0", rd2, 32'h0);
    bus_read(5'h11); checkOutput("baddr1", rd2, 32'h0);
    for (int a = 13; a < 32; a++) begin
      if (a != 16 && a != 17) begin
        bus_read(5'(a));
        checkOutput($sformatf("unmapped_%02h", a), rd2, 32'h0);
      end
    end

    // Buffer-done event timing and interrupt
    bus_write(5'h02, 32'h1);
    @(negedge clk); buff_tgl2[0] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("irq_k2", {31'd0, irq2}, 32'd0);
    @(negedge clk);
    checkOutput("irq_k3", {31'd0, irq2}, 32'd1);
    bus_read(5'h01); checkOutput("status_b0", rd2, 32'h001);
    bus_write(5'h01, 32'h1);
    @(negedge clk);
    checkOutput("irq_clr", {31'd0, irq2}, 32'd0);
    bus_read(5'h01); checkOutput("status_clr", rd2, 32'h0);

    // Overrun, masked irq, set-vs-clear race
    applyStimulus(1);
    applyStimulus(1);
    bus_read(5'h01); checkOutput("overrun", rd2, 32'h202);
    checkOutput("irq_masked", {31'd0, irq2}, 32'd0);
    bus_write(5'h01, 32'h303);
    applyStimulus(1);
    bus_write(5'h01, 32'h0);
    bus_read(5'h01); checkOutput("w0_noeffect", rd2, 32'h002);
    @(negedge clk); buff_tgl2[1] = ~buff_tgl2[1];
    @(negedge clk);
    bus_write(5'h01, 32'h2);
    bus_read(5'h01); checkOutput("set_wins", rd2, 32'h002);

    // CTRL outputs and shadowed configuration
    bus_write(5'h00, 32'h1);
    checkOutput("soft_low", {31'd0, soft2}, 32'd0);
    checkOutput("start_hi", {31'd0, start2}, 32'd1);
    bus_write(5'h00, 32'h3);
    bus_write(5'h0A, 32'h0100);
    repeat (2) @(negedge clk);
    checkOutput("cfg_hold", {16'd0, c2_ex}, 32'h07c0);
    bus_read(5'h0A); checkOutput("shadow_rd", rd2, 32'h0100);
    @(negedge clk); frame_start_tgl = ~frame_start_tgl;
    repeat (2) @(negedge clk);
    checkOutput("cfg_k1", {16'd0, c2_ex}, 32'h07c0);
    @(negedge clk);
    checkOutput("cfg_k2", {16'd0, c2_ex}, 32'h0100);
    bus_read(5'h03); checkOutput("frame1", rd2, 32'h1);
    bus_write(5'h00, 32'h2);
    bus_write(5'h0B, 32'h0280);
    @(negedge clk);
    checkOutput("cfg_stopped", {16'd0, c2_w}, 32'h0280);
    bus_write(5'h10, 32'h1234_5678);
    checkOutput("baddr_out", baddr2[31:0], 32'h1234_5678);

    // Frame counter wrap and clear-vs-increment race
    @(negedge clk); force u_dut.frame_cnt = 16'hFFFF;
    @(negedge clk); release u_dut.frame_cnt;
    bus_read(5'h03); checkOutput("frame_ffff", rd2, 32'hFFFF);
    applyStimulus(-1);
    bus_read(5'h03); checkOutput("frame_wrap", rd2, 32'h0);
    applyStimulus(-1);
    applyStimulus(-1);
    bus_read(5'h03); checkOutput("frame2", rd2, 32'h2);
    @(negedge clk); frame_start_tgl = ~frame_start_tgl;
    @(negedge clk);
    bus_write(5'h03, 32'h0);
    repeat (3) @(negedge clk);
    bus_read(5'h03); checkOutput("frame_clr_wins", rd2, 32'h0);

    // Reset with toggle inputs held high
    @(negedge clk);
    buff_tgl2 = 2'b11; buff_tgl4 = 4'b1111;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_cfg", {16'd0, c2_ex}, 32'h07c0);
    checkOutput("mid_rst_baddr", baddr2[31:0], 32'h0);
    @(negedge clk); reset_n = 1'b1;
    repeat (6) @(negedge clk);
    bus_read(5'h01);
    checkOutput("no_false_ev2", rd2, 32'h0);
    checkOutput("no_false_ev4", rd4, 32'h0);

    // Four-buffer instance
    bus_write(5'h13, 32'hDEAD_BEEF);
    bus_read(5'h13);
    checkOutput("baddr3_rd4", rd4, 32'hDEAD_BEEF);
    checkOutput("baddr3_rd2", rd2, 32'h0);
    checkOutput("baddr3_out", baddr4[127:96], 32'hDEAD_BEEF);
    applyStimulus(5);
    bus_read(5'h01); checkOutput("status4_b3", rd4, 32'h008);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
